// File: rtl/step_pulse_ctrl.sv
// step_pulse_ctrl: pushbutton step controller for clocked sequential datapaths.
// A prescaler divides MHz into a sampling tick. PS3 is debounced by a
// press/release FSM that advances only on ticks. Each accepted press issues
// a single-cycle step enable, with the synchronized W captured alongside it.
// Optional feature macro: STEP_AUTOREPEAT_EN (auto-repeat steps while held).
module step_pulse_ctrl #(
    parameter int DIV          = 10000,
    parameter int DB_TICKS     = 11
`ifdef STEP_AUTOREPEAT_EN
   ,parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
`endif
) (
    input  logic       MHz,
    input  logic       Reset,
    input  logic       PS3,
    input  logic       W,
    output logic       tick,
    output logic       step,
    output logic       w_smp,
    output logic       held,
    output logic [7:0] step_cnt
);

    localparam int PRE_W = $clog2(DIV);
    localparam int DB_W  = $clog2(DB_TICKS) + 1;

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    logic             ps3_m, ps3_s;
    logic             w_m, w_s;
    logic [PRE_W-1:0] pre_cnt;
    logic [DB_W-1:0]  db_cnt;
    state_t           state;

`ifdef STEP_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_nxt;
    assign rpt_nxt = rpt_cnt + 1'b1;
`endif

    // Two-flop synchronizers for the asynchronous button and data switch
    always_ff @(posedge MHz) begin
        if (Reset) begin
            ps3_m <= 1'b0;
            ps3_s <= 1'b0;
            w_m   <= 1'b0;
            w_s   <= 1'b0;
        end else begin
            ps3_m <= PS3;
            ps3_s <= ps3_m;
            w_m   <= W;
            w_s   <= w_m;
        end
    end

    // Prescaler: counts 0..DIV-1, tick is the terminal-count decode
    always_ff @(posedge MHz) begin
        if (Reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_W'(DIV - 1)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == PRE_W'(DIV - 1));

    // Debounce FSM with registered step, captured W and held decode
    always_ff @(posedge MHz) begin
        if (Reset) begin
            state   <= IDLE;
            db_cnt  <= '0;
            step    <= 1'b0;
            w_smp   <= 1'b0;
            held    <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
            rpt_cnt <= '0;
`endif
        end else begin
            // step only ever lasts one cycle; ticks are at least two clocks apart
            step <= 1'b0;
            held <= (state == HELD) || (state == REL);
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (ps3_s) begin
                            state  <= ARM;
                            db_cnt <= DB_W'(1);
                        end
                    end
                    ARM: begin
                        if (!ps3_s) begin
                            state  <= IDLE;
                            db_cnt <= '0;
                        end else if (db_cnt == DB_W'(DB_TICKS - 1)) begin
                            state   <= HELD;
                            db_cnt  <= '0;
                            step    <= 1'b1;
                            w_smp   <= w_s;
`ifdef STEP_AUTOREPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!ps3_s) begin
                            state   <= REL;
                            db_cnt  <= DB_W'(1);
`ifdef STEP_AUTOREPEAT_EN
                            rpt_cnt <= '0;
                        end else if (rpt_nxt == RPT_W'(REPEAT_DELAY + REPEAT_RATE)) begin
                            // fold back so each later repeat is REPEAT_RATE ticks apart
                            rpt_cnt <= RPT_W'(REPEAT_DELAY);
                            step    <= 1'b1;
                            w_smp   <= w_s;
                        end else begin
                            rpt_cnt <= rpt_nxt;
                            if (rpt_nxt == RPT_W'(REPEAT_DELAY)) begin
                                step  <= 1'b1;
                                w_smp <= w_s;
                            end
`endif
                        end
                    end
                    REL: begin
                        if (ps3_s) begin
                            state   <= HELD;
                            db_cnt  <= '0;
`ifdef STEP_AUTOREPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else if (db_cnt == DB_W'(DB_TICKS - 1)) begin
                            state  <= IDLE;
                            db_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Step counter, wraps naturally at 8 bits
    always_ff @(posedge MHz) begin
        if (Reset) begin
            step_cnt <= '0;
        end else if (step) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_step_pulse_ctrl.sv
// tb_step_pulse_ctrl: directed bench for step_pulse_ctrl with a run-length
// debounce model compared against every output on every cycle.
module tb_step_pulse_ctrl;

    localparam int DIV          = 4;
    localparam int DB_TICKS     = 3;
    localparam int REPEAT_DELAY = 4;
    localparam int REPEAT_RATE  = 2;
`ifdef STEP_AUTOREPEAT_EN
    localparam int P20 = 8;   // 20 held samples: press step + repeats at +4,+6,...,+16
`else
    localparam int P20 = 1;
`endif

    logic       MHz = 1'b0;
    logic       Reset = 1'b1;
    logic       PS3 = 1'b0;
    logic       W = 1'b0;
    logic       tick, step, w_smp, held;
    logic [7:0] step_cnt;

    int total = 0;
    int bad   = 0;
    int step_seen = 0;
    int tick_seen = 0;

    step_pulse_ctrl #(
        .DIV(DIV),
        .DB_TICKS(DB_TICKS)
`ifdef STEP_AUTOREPEAT_EN
       ,.REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE)
`endif
    ) dut (
        .MHz(MHz),
        .Reset(Reset),
        .PS3(PS3),
        .W(W),
        .tick(tick),
        .step(step),
        .w_smp(w_smp),
        .held(held),
        .step_cnt(step_cnt)
    );

    always #5 MHz = ~MHz;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit model_on = 1'b0;
    int m_cyc = 0;
    bit s1 = 0, s2 = 0, ws1 = 0, ws2 = 0;
    bit acc = 0;          // accepted button level
    int run = 0;          // consecutive tick samples disagreeing with acc
    int hk = 0;           // ticks held since acceptance (auto-repeat)
    bit e_tick = 0, e_step = 0, e_w = 0, e_held = 0;
    int e_cnt = 0;

    task automatic model_edge();
        bit t, fire, acc_old, ps, wsv;
        if (Reset) begin
            model_on = 1'b1;
            m_cyc = 0; s1 = 0; s2 = 0; ws1 = 0; ws2 = 0;
            acc = 0; run = 0; hk = 0;
            e_tick = 0; e_step = 0; e_w = 0; e_held = 0; e_cnt = 0;
            return;
        end
        t       = ((m_cyc % DIV) == DIV - 1);
        ps      = s2;
        wsv     = ws2;
        acc_old = acc;
        fire    = 1'b0;
        if (t) begin
            if (ps != acc) begin
                run++;
                hk = 0;
                if (run == DB_TICKS) begin
                    acc = ps;
                    run = 0;
                    if (ps) fire = 1'b1;
                end
            end else begin
                if (acc && run == 0) begin
                    hk++;
`ifdef STEP_AUTOREPEAT_EN
                    if (hk >= REPEAT_DELAY && ((hk - REPEAT_DELAY) % REPEAT_RATE) == 0) fire = 1'b1;
`endif
                end else begin
                    hk = 0;
                end
                run = 0;
            end
        end
        e_cnt  = (e_cnt + int'(e_step)) % 256;
        if (fire) e_w = wsv;
        e_step = fire;
        e_held = acc_old;
        s2 = s1; s1 = PS3; ws2 = ws1; ws1 = W;
        m_cyc++;
        e_tick = ((m_cyc % DIV) == DIV - 1);
    endtask

    initial forever begin
        @(posedge MHz);
        model_edge();
    end

    // Per-cycle comparison of all outputs, away from the active edge
    initial forever begin
        @(negedge MHz);
        if (step) step_seen++;
        if (tick) tick_seen++;
        if (model_on)
            chk("outputs{tick,step,w_smp,held,cnt}",
                int'({tick, step, w_smp, held, step_cnt}),
                int'({e_tick, e_step, e_w, e_held, 8'(e_cnt)}));
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge MHz);
        #1;
    endtask

    task automatic wait_tick();
        bit got = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge MHz);
            if (tick) begin
                got = 1'b1;
                break;
            end
        end
        chk("tick_wait", int'(got), 1);
        @(posedge MHz);
        #1;
    endtask

    initial begin
        int s0, t0;

        // 1. reset, idle ticking
        Reset = 1'b1; PS3 = 1'b0; W = 1'b0;
        clocks(2);
        Reset = 1'b0;
        chk("rst_step", int'(step), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_cnt", int'(step_cnt), 0);
        chk("rst_tick", int'(tick), 0);
        t0 = tick_seen;
        clocks(16);
        chk("ticks_in_16", tick_seen - t0, 4);

        // 2. clean press with W=1
        W = 1'b1; PS3 = 1'b1;
        s0 = step_seen;
        clocks(20 * DIV);
        chk("press_steps", step_seen - s0, P20);
        chk("press_wsmp", int'(w_smp), 1);
        chk("press_cnt", int'(step_cnt), P20);
        chk("press_held", int'(held), 1);

        // 4. release with one high bounce mid-release
        W = 1'b0; PS3 = 1'b0;
        s0 = step_seen;
        clocks(DIV);
        PS3 = 1'b1;
        clocks(DIV);
        PS3 = 1'b0;
        clocks(6 * DIV);
        chk("rel_steps", step_seen - s0, 0);
        chk("rel_held", int'(held), 0);
        chk("rel_cnt", int'(step_cnt), P20);
        chk("rel_wsmp_hold", int'(w_smp), 1);

        // 3. press bounce: 1 high, 1 low, 1 high tick
        s0 = step_seen;
        PS3 = 1'b1; clocks(DIV);
        PS3 = 1'b0; clocks(DIV);
        PS3 = 1'b1; clocks(DIV);
        PS3 = 1'b0; clocks(6 * DIV);
        chk("bounce_steps", step_seen - s0, 0);
        chk("bounce_held", int'(held), 0);

        // 5. reset while in ARM with db_cnt=2
        PS3 = 1'b1;
        clocks(2);
        wait_tick();
        wait_tick();
        chk("arm_no_step_yet", int'(step_cnt), P20);
        Reset = 1'b1;
        @(posedge MHz); #1;
        Reset = 1'b0;
        chk("armrst_step", int'(step), 0);
        chk("armrst_held", int'(held), 0);
        chk("armrst_cnt", int'(step_cnt), 0);
        chk("armrst_wsmp", int'(w_smp), 0);
        PS3 = 1'b0; clocks(4 * DIV);
        PS3 = 1'b1; clocks(6 * DIV);
        chk("after_rst_press_cnt", int'(step_cnt), 1);
        PS3 = 1'b0; clocks(6 * DIV);

        // 6. 256 clean presses wrap the counter
        Reset = 1'b1; clocks(1); Reset = 1'b0;
        s0 = step_seen;
        for (int i = 0; i < 256; i++) begin
            PS3 = 1'b1; clocks(5 * DIV);
            PS3 = 1'b0; clocks(5 * DIV);
            if (i == 254) chk("cnt_255", int'(step_cnt), 255);
        end
        chk("wrap_cnt", int'(step_cnt), 0);
        chk("wrap_steps", step_seen - s0, 256);

`ifdef STEP_AUTOREPEAT_EN
        // auto-repeat: 13 held samples -> steps at press, +4, +6, +8, +10
        Reset = 1'b1; clocks(1); Reset = 1'b0;
        s0 = step_seen;
        PS3 = 1'b1; clocks(13 * DIV);
        PS3 = 1'b0; clocks(6 * DIV);
        chk("repeat_steps", step_seen - s0, 5);
        chk("repeat_cnt", int'(step_cnt), 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
